// File: rtl/ped_xing_pkg.sv
// ============================================================================
// Module : ped_xing_pkg
// Brief  : Shared types and sizing helper for the pedestrian crossing block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ped_xing_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } sig_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    WALK    = 3'd2,
    CLEAR   = 3'd3,
    LOCKOUT = 3'd4
  } ped_state_e;

  // Width of a down-timer that must hold (max of the three durations) - 1.
  function automatic int TIMER_W(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 3) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pedestrian_crossing_ctrl_button_debouncer.sv
// ============================================================================
// Module : button_debouncer
// Brief  : 2-FF synchroniser, stability-count debouncer, rising-edge pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_i,
  input  logic button_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 3) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/pedestrian_crossing_ctrl.sv
// ============================================================================
// Module : pedestrian_crossing_ctrl
// Brief  : Walk-request FSM with lamps and countdown; PED_AUDIO_EN adds audio_o.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pedestrian_crossing_ctrl
  import ped_xing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 8,
  parameter int CLEAR_CYCLES    = 3,
  parameter int LOCKOUT_CYCLES  = 16,
  parameter int FLASH_DIV       = 2
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       button_i,
  input  logic [1:0] signal_i,
  output logic       walk_o,
  output logic       walk_lamp_o,
  output logic       dont_walk_lamp_o,
  output logic       wait_lamp_o,
  output logic [7:0] countdown_o
`ifdef PED_AUDIO_EN
  ,
  output logic       audio_o
`endif
);

  localparam int TW = TIMER_W(WALK_CYCLES, CLEAR_CYCLES, LOCKOUT_CYCLES);
  localparam logic [TW-1:0] WALK_LOAD    = TW'(WALK_CYCLES - 1);
  localparam logic [TW-1:0] CLEAR_LOAD   = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam int FW = (FLASH_DIV < 3) ? 1 : $clog2(FLASH_DIV);
  localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_DIV - 1);

  logic press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .rst_i   (rst_i),
    .button_i(button_i),
    .press_o (press)
  );

  ped_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_on_q, flash_on_d;
  logic          walk_q, walk_d;
  logic          walk_lamp_q, walk_lamp_d;
  logic          dont_walk_q, dont_walk_d;
  logic          wait_q, wait_d;
  logic [7:0]    countdown_q, countdown_d;
  logic [31:0]   cd_wide;
  logic          is_red;

  assign is_red = (signal_i == RED);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (press) state_d = REQUEST;
      end
      REQUEST: begin
        if (is_red) begin
          state_d = WALK;
          timer_d = WALK_LOAD;
        end
      end
      WALK: begin
        if (press) pending_d = 1'b1;
        if (!is_red || timer_q == '0) begin
          state_d = CLEAR;
          timer_d = CLEAR_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      CLEAR: begin
        if (press) pending_d = 1'b1;
        if (timer_q == '0) begin
          state_d = LOCKOUT;
          timer_d = LOCKOUT_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      LOCKOUT: begin
        if (press) pending_d = 1'b1;
        if (timer_q == '0) begin
          // A press landing on the expiry cycle still counts as a request.
          state_d = (pending_q || press) ? REQUEST : IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    if (state_d == REQUEST) pending_d = 1'b0;

    flash_cnt_d = '0;
    flash_on_d  = 1'b1;
    if (state_d == CLEAR && state_q == CLEAR) begin
      if (flash_cnt_q == FLASH_MAX) begin
        flash_on_d = ~flash_on_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
        flash_on_d  = flash_on_q;
      end
    end

    walk_d      = (state_d == REQUEST) || (state_d == WALK);
    walk_lamp_d = (state_d == WALK);
    wait_d      = pending_d || (state_d == REQUEST);
    if (state_d == WALK) begin
      dont_walk_d = 1'b0;
    end else if (state_d == CLEAR) begin
      dont_walk_d = flash_on_d;
    end else begin
      dont_walk_d = 1'b1;
    end

    if (state_d == WALK) begin
      cd_wide = 32'(timer_d) + 32'(CLEAR_CYCLES);
    end else if (state_d == CLEAR) begin
      cd_wide = 32'(timer_d) + 32'd1;
    end else begin
      cd_wide = 32'd0;
    end
    countdown_d = (cd_wide > 32'd255) ? 8'hFF : cd_wide[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      pending_q   <= 1'b0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
      walk_q      <= 1'b0;
      walk_lamp_q <= 1'b0;
      dont_walk_q <= 1'b1;
      wait_q      <= 1'b0;
      countdown_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      walk_q      <= walk_d;
      walk_lamp_q <= walk_lamp_d;
      dont_walk_q <= dont_walk_d;
      wait_q      <= wait_d;
      countdown_q <= countdown_d;
    end
  end

  assign walk_o           = walk_q;
  assign walk_lamp_o      = walk_lamp_q;
  assign dont_walk_lamp_o = dont_walk_q;
  assign wait_lamp_o      = wait_q;
  assign countdown_o      = countdown_q;

`ifdef PED_AUDIO_EN
  logic       audio_q, audio_d;
  logic [1:0] audio_cnt_q, audio_cnt_d;

  always_comb begin
    audio_d     = 1'b0;
    audio_cnt_d = 2'd0;
    if (state_d == WALK) begin
      audio_d = ~audio_q;
    end else if (state_d == CLEAR) begin
      audio_cnt_d = audio_cnt_q + 2'd1;
      audio_d     = (audio_cnt_q == 2'd3) ? ~audio_q : audio_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      audio_q     <= 1'b0;
      audio_cnt_q <= 2'd0;
    end else begin
      audio_q     <= audio_d;
      audio_cnt_q <= audio_cnt_d;
    end
  end

  assign audio_o = audio_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pedestrian_crossing_ctrl.sv
// ============================================================================
// Module : tb_pedestrian_crossing_ctrl
// Brief  : Directed vector table plus multi-cycle corner sequences.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pedestrian_crossing_ctrl;

  localparam logic [1:0] S_RED   = 2'd0;
  localparam logic [1:0] S_GREEN = 2'd1;
  localparam logic [1:0] S_INV   = 2'd3;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       button_i;
  logic [1:0] signal_i;
  logic       walk_o, walk_lamp_o, dont_walk_lamp_o, wait_lamp_o;
  logic [7:0] countdown_o;
`ifdef PED_AUDIO_EN
  logic       audio_o;
`endif

  pedestrian_crossing_ctrl dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .button_i        (button_i),
    .signal_i        (signal_i),
    .walk_o          (walk_o),
    .walk_lamp_o     (walk_lamp_o),
    .dont_walk_lamp_o(dont_walk_lamp_o),
    .wait_lamp_o     (wait_lamp_o),
    .countdown_o     (countdown_o)
`ifdef PED_AUDIO_EN
    ,
    .audio_o         (audio_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       btn;
    logic [1:0] sig;
    logic       walk;
    logic       lamp;
    logic       dw;
    logic       wt;
    logic [7:0] cd;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic apply(input logic r, input logic b, input logic [1:0] s);
    rst_i    = r;
    button_i = b;
    signal_i = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic w, input logic l,
                       input logic d, input logic t, input logic [7:0] cd);
    checks++;
    if ({walk_o, walk_lamp_o, dont_walk_lamp_o, wait_lamp_o, countdown_o} !== {w, l, d, t, cd}) begin
      errors++;
      $display("FAIL %s: got walk=%b lamp=%b dont_walk=%b wait=%b cd=%0d, expected walk=%b lamp=%b dont_walk=%b wait=%b cd=%0d",
               name, walk_o, walk_lamp_o, dont_walk_lamp_o, wait_lamp_o, countdown_o, w, l, d, t, cd);
    end
  endtask

  task automatic step_chk(input string name, input logic w, input logic l,
                          input logic d, input logic t, input logic [7:0] cd);
    tick();
    check(name, w, l, d, t, cd);
  endtask

  task automatic add(input logic r, input logic b, input logic [1:0] s, input logic w,
                     input logic l, input logic d, input logic t, input logic [7:0] cd, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{r, b, s, w, l, d, t, cd});
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, S_GREEN);
    step_chk("reset", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    rst_i = 1'b0;
  endtask

  // Leaves the DUT in REQUEST with the debounced button back low.
  task automatic get_request();
    apply(1'b0, 1'b1, S_GREEN);
    for (int i = 0; i < 6; i++) step_chk("debounce_idle", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    step_chk("request_rise", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
    button_i = 1'b0;
    for (int i = 0; i < 6; i++) step_chk("request_hold", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
  endtask

  initial begin
    apply(1'b1, 1'b0, S_GREEN);

    add(1'b1, 1'b0, S_GREEN, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2);
    add(1'b0, 1'b1, S_GREEN, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 6);
    add(1'b0, 1'b1, S_GREEN, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 14);
    add(1'b0, 1'b0, S_GREEN, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 6);
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b0, S_RED, 1'b1, 1'b1, 1'b0, 1'b0, 8'(10 - k), 1);
    add(1'b0, 1'b0, S_RED, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 1);
    add(1'b0, 1'b0, S_RED, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 1);
    add(1'b0, 1'b0, S_RED, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1);
    add(1'b0, 1'b0, S_RED, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16);
    add(1'b0, 1'b0, S_GREEN, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].btn, tbl[i].sig);
      tick();
      check($sformatf("vec%0d", i), tbl[i].walk, tbl[i].lamp, tbl[i].dw, tbl[i].wt, tbl[i].cd);
    end

    // Three-cycle glitch never produces a request.
    do_reset();
    button_i = 1'b1;
    for (int i = 0; i < 3; i++) step_chk("glitch_on", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    button_i = 1'b0;
    for (int i = 0; i < 12; i++) step_chk("glitch_off", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    // Four-cycle pulse is exactly long enough.
    do_reset();
    button_i = 1'b1;
    for (int i = 0; i < 4; i++) step_chk("thresh_on", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    button_i = 1'b0;
    for (int i = 0; i < 2; i++) step_chk("thresh_wait", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    step_chk("thresh_request", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);

    // Signal leaves RED on WALK cycle 3.
    do_reset();
    get_request();
    signal_i = S_RED;
    step_chk("abort_walk1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd10);
    step_chk("abort_walk2", 1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
    step_chk("abort_walk3", 1'b1, 1'b1, 1'b0, 1'b0, 8'd8);
    signal_i = S_GREEN;
    step_chk("abort_clear1", 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    step_chk("abort_clear2", 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
    step_chk("abort_clear3", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    step_chk("abort_lockout", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    // Invalid signal code 3 is not RED.
    do_reset();
    get_request();
    signal_i = S_INV;
    step_chk("inv_request", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
    signal_i = S_RED;
    step_chk("inv_walk", 1'b1, 1'b1, 1'b0, 1'b0, 8'd10);
    signal_i = S_INV;
    step_chk("inv_abort", 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);

    // Press during WALK is served 16 cycles after CLEAR ends.
    do_reset();
    get_request();
    apply(1'b0, 1'b1, S_RED);
    for (int i = 0; i < 6; i++) step_chk("pend_walk", 1'b1, 1'b1, 1'b0, 1'b0, 8'(10 - i));
    step_chk("pend_set", 1'b1, 1'b1, 1'b0, 1'b1, 8'd4);
    step_chk("pend_walk_last", 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
    button_i = 1'b0;
    step_chk("pend_clear1", 1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
    step_chk("pend_clear2", 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
    step_chk("pend_clear3", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    signal_i = S_GREEN;
    for (int i = 0; i < 16; i++) step_chk("pend_lockout", 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    step_chk("pend_request", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);

    // Reset mid-WALK with a pending press discards everything.
    do_reset();
    get_request();
    apply(1'b0, 1'b1, S_RED);
    for (int i = 0; i < 6; i++) step_chk("rst_walk", 1'b1, 1'b1, 1'b0, 1'b0, 8'(10 - i));
    step_chk("rst_pend_set", 1'b1, 1'b1, 1'b0, 1'b1, 8'd4);
    apply(1'b1, 1'b0, S_RED);
    step_chk("rst_mid_walk", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 25; i++) step_chk("rst_no_replay", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
